// File: rtl/btn_evt_uart_pkg.sv
// Shared constants for the button-event UART path: character table,
// release-case offset and scanner state encodings.
package btn_evt_uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  localparam logic [7:0] CASE_BIT = 8'h20;

  // Press character per button index; release adds CASE_BIT (lowercase).
  function automatic logic [7:0] btn_char(input logic [3:0] idx);
    logic [7:0] c;
    case (idx)
      4'd0:    c = 8'h44; // D joystick down
      4'd1:    c = 8'h55; // U joystick up
      4'd2:    c = 8'h4C; // L joystick left
      4'd3:    c = 8'h52; // R joystick right
      4'd4:    c = 8'h50; // P joystick press
      4'd5:    c = 8'h41; // A
      4'd6:    c = 8'h42; // B
      4'd7:    c = 8'h53; // S start
      4'd8:    c = 8'h45; // E select
      4'd9:    c = 8'h4D; // M menu
      4'd10:   c = 8'h48; // H home
      4'd11:   c = 8'h56; // V
      4'd12:   c = 8'h57; // W
      4'd13:   c = 8'h58; // X
      4'd14:   c = 8'h59; // Y
      default: c = 8'h5A; // Z
    endcase
    return c;
  endfunction

endpackage

// File: rtl/btn_evt_uart_fifo.sv
// Shift-register sync FIFO with a registered first-word output stage.
// A word is consumed when rd_valid and rd_ena are both high.
module fifo_sync_shift #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] wr_data,
  input  logic          wr_ena,
  output logic          full,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  input  logic          rd_ena
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] out_q, out_d;
  logic          out_vld_q, out_vld_d;

  logic          out_free;
  logic          stor_pop;
  logic          wr_ok;
  logic          bypass;
  logic          store;
  logic [AW:0]   wr_idx;

  always_comb begin
    out_free  = !out_vld_q || rd_ena;
    stor_pop  = out_free && (count_q != '0);
    wr_ok     = wr_ena && ((count_q != FULL_CNT) || stor_pop);
    // An empty FIFO forwards the write straight into a free output stage.
    bypass    = wr_ok && out_free && (count_q == '0);
    store     = wr_ok && !bypass;
    wr_idx    = count_q - {{AW{1'b0}}, stor_pop};

    out_d     = out_q;
    out_vld_d = out_vld_q;
    if (out_free) begin
      if (stor_pop) begin
        out_d     = mem_q[0];
        out_vld_d = 1'b1;
      end else if (bypass) begin
        out_d     = wr_data;
        out_vld_d = 1'b1;
      end else begin
        out_vld_d = 1'b0;
      end
    end

    mem_d = mem_q;
    if (stor_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_d[i] = mem_q[i+1];
      end
    end
    if (store) begin
      mem_d[wr_idx[AW-1:0]] = wr_data;
    end

    count_d = count_q - {{AW{1'b0}}, stor_pop} + {{AW{1'b0}}, store};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q     <= '{default: '0};
      count_q   <= '0;
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      count_q   <= count_d;
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign full     = (count_q == FULL_CNT);
  assign rd_data  = out_q;
  assign rd_valid = out_vld_q;

endmodule

// File: rtl/btn_evt_uart.sv
// Turns button reports into one ASCII character per changed button and
// queues them towards the UART transmitter; counts reports dropped while busy.
module btn_evt_uart #(
  parameter int N_BTN   = 16,
  parameter int FIFO_AW = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] rpt_state,
  input  logic [N_BTN-1:0] rpt_change,
  input  logic             rpt_stb,
  output logic [7:0]       uart_data,
  output logic             uart_valid,
  input  logic             uart_ack,
  output logic             busy,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic [7:0]       drop_cnt
);

  import btn_evt_uart_pkg::*;

  scan_state_e      state_q, state_d;
  logic [N_BTN-1:0] pend_chg_q, pend_chg_d;
  logic [N_BTN-1:0] pend_st_q, pend_st_d;
  logic             ovf_q, ovf_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  logic [N_BTN-1:0] low_oh;
  logic [3:0]       low_idx;
  logic             low_pressed;
  logic             push;
  logic [7:0]       push_char;
  logic             fifo_full;
  logic             drop;

  // Lowest pending change bit: one-hot mask plus its index.
  always_comb begin
    low_oh  = pend_chg_q & (~pend_chg_q + N_BTN'(1));
    low_idx = '0;
    for (int i = N_BTN - 1; i >= 0; i--) begin
      if (pend_chg_q[i]) low_idx = 4'(i);
    end
    low_pressed = |(low_oh & pend_st_q);
    push_char   = btn_char(low_idx) + (low_pressed ? 8'h00 : CASE_BIT);
  end

  always_comb begin
    state_d    = state_q;
    pend_chg_d = pend_chg_q;
    pend_st_d  = pend_st_q;
    push       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rpt_stb) begin
          pend_chg_d = rpt_change;
          pend_st_d  = rpt_state;
          if (|rpt_change) state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        // A full FIFO stalls the scan; pending bits are held, never lost.
        if (!fifo_full) begin
          push       = 1'b1;
          pend_chg_d = pend_chg_q & ~low_oh;
          if (pend_chg_d == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    drop       = rpt_stb && (state_q == ST_SCAN);
    ovf_d      = ovf_q;
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr) begin
      ovf_d      = 1'b0;
      drop_cnt_d = '0;
    end
    // A drop in the same cycle as a clear still counts as the first drop.
    if (drop) begin
      ovf_d = 1'b1;
      if (ovf_clr)                  drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_chg_q <= '0;
      pend_st_q  <= '0;
      ovf_q      <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pend_chg_q <= pend_chg_d;
      pend_st_q  <= pend_st_d;
      ovf_q      <= ovf_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  fifo_sync_shift #(
    .AW (FIFO_AW),
    .DW (8)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_data  (push_char),
    .wr_ena   (push),
    .full     (fifo_full),
    .rd_data  (uart_data),
    .rd_valid (uart_valid),
    .rd_ena   (uart_ack)
  );

  assign busy     = (state_q == ST_SCAN);
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_btn_evt_uart.sv
// Scoreboard bench for btn_evt_uart: expected characters are queued from a
// reference character model when reports are driven, then popped against output.
module tb_btn_evt_uart;

  logic        clk;
  logic        rst;
  logic [15:0] rpt_state;
  logic [15:0] rpt_change;
  logic        rpt_stb;
  logic [7:0]  uart_data;
  logic        uart_valid;
  logic        uart_ack;
  logic        busy;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;

  logic [7:0] exp_q[$];
  logic [7:0] rcv_q[$];
  logic [7:0] ack_data;
  logic [7:0] tbl [16] = '{8'h44, 8'h55, 8'h4C, 8'h52, 8'h50, 8'h41, 8'h42, 8'h53,
                           8'h45, 8'h4D, 8'h48, 8'h56, 8'h57, 8'h58, 8'h59, 8'h5A};
  int n_cmp;
  int n_fail;

  btn_evt_uart #(.N_BTN(16), .FIFO_AW(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rpt_state  (rpt_state),
    .rpt_change (rpt_change),
    .rpt_stb    (rpt_stb),
    .uart_data  (uart_data),
    .uart_valid (uart_valid),
    .uart_ack   (uart_ack),
    .busy       (busy),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .drop_cnt   (drop_cnt)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: one character per changed bit, lowest index first.
  task automatic exp_push(input logic [15:0] st, input logic [15:0] ch);
    for (int i = 0; i < 16; i++) begin
      if (ch[i]) exp_q.push_back(st[i] ? tbl[i] : tbl[i] + 8'h20);
    end
  endtask

  // Drivers
  task automatic send_report(input logic [15:0] st, input logic [15:0] ch);
    @(negedge clk);
    rpt_state  = st;
    rpt_change = ch;
    rpt_stb    = 1'b1;
    @(negedge clk);
    rpt_stb    = 1'b0;
  endtask

  task automatic collect(input int n, input int budget);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (uart_ack) begin
        rcv_q.push_back(ack_data);
        got++;
        uart_ack = 1'b0;
      end else if (uart_valid) begin
        uart_ack = 1'b1;
        ack_data = uart_data;
      end
    end
    uart_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++; if (uart_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", uart_valid); end
    n_cmp++; if (uart_data !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", uart_data); end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
    n_cmp++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_single();
    logic [7:0] e;
    logic [7:0] g;
    exp_push(16'h0001, 16'h0001);
    send_report(16'h0001, 16'h0001);
    n_cmp++; if (uart_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_early got=%b exp=0", uart_valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", busy); end
    @(negedge clk);
    n_cmp++; if (uart_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency got=%b exp=1", uart_valid); end
    collect(1, 20);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rcv_q.size() == 0) begin n_fail++; $display("FAIL single_char got=none exp=%h", e); end
      else begin g = rcv_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL single_char got=%h exp=%h", g, e); end end
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (uart_valid !== 1'b0) begin n_fail++; $display("FAIL single_extra got=%b exp=0", uart_valid); end
  endtask

  task automatic test_multi();
    int cnt;
    logic [7:0] e;
    logic [7:0] g;
    exp_push(16'h0005, 16'h000F);
    send_report(16'h0005, 16'h000F);
    cnt = 0;
    while (busy === 1'b1 && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL multi_busy_cycles got=%0d exp=4", cnt); end
    collect(4, 40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rcv_q.size() == 0) begin n_fail++; $display("FAIL multi_char got=none exp=%h", e); end
      else begin g = rcv_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL multi_char got=%h exp=%h", g, e); end end
    end
  endtask

  // Ack held low: 17 slots take report 1 plus one char of report 2, which then stalls.
  task automatic test_fill();
    logic [15:0] s1;
    logic [15:0] s2;
    logic [7:0]  e;
    logic [7:0]  g;
    s1 = 16'($urandom_range(0, 16'hFFFF));
    s2 = 16'($urandom_range(0, 16'hFFFF));
    exp_push(s1, 16'hFFFF);
    send_report(s1, 16'hFFFF);
    repeat (40) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL fill_busy_r1 got=%b exp=0", busy); end
    exp_push(s2, 16'hFFFF);
    send_report(s2, 16'hFFFF);
    repeat (40) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL fill_stall got=%b exp=1", busy); end
    send_report(16'h1234, 16'hFFFF);
    repeat (40) @(negedge clk);
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL fill_ovf got=%b exp=1", ovf); end
    n_cmp++; if (drop_cnt !== 8'd1) begin n_fail++; $display("FAIL fill_drop1 got=%0d exp=1", drop_cnt); end
    send_report(16'h4321, 16'hFFFF);
    @(negedge clk);
    n_cmp++; if (drop_cnt !== 8'd2) begin n_fail++; $display("FAIL fill_drop2 got=%0d exp=2", drop_cnt); end
    collect(32, 300);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rcv_q.size() == 0) begin n_fail++; $display("FAIL fill_char got=none exp=%h", e); end
      else begin g = rcv_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL fill_char got=%h exp=%h", g, e); end end
    end
    repeat (5) @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || uart_valid !== 1'b0) begin n_fail++; $display("FAIL fill_idle got=%b%b exp=00", busy, uart_valid); end
  endtask

  task automatic test_saturate();
    logic [7:0] e;
    logic [7:0] g;
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    exp_push(16'h00FF, 16'hFFFF);
    send_report(16'h00FF, 16'hFFFF);
    repeat (20) @(negedge clk);
    exp_push(16'hFF00, 16'hFFFF);
    send_report(16'hFF00, 16'hFFFF);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 254; i++) send_report(16'h0000, 16'h0001);
    n_cmp++; if (drop_cnt !== 8'd254) begin n_fail++; $display("FAIL sat_254 got=%0d exp=254", drop_cnt); end
    send_report(16'h0000, 16'h0001);
    n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_255 got=%0d exp=255", drop_cnt); end
    for (int i = 0; i < 45; i++) send_report(16'h0000, 16'h0001);
    n_cmp++; if (drop_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_hold got=%0d exp=255", drop_cnt); end
    n_cmp++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL sat_ovf got=%b exp=1", ovf); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_cmp++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL sat_clr got=%b/%0d exp=0/0", ovf, drop_cnt); end
    ovf_clr = 1'b1;
    rpt_stb = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    rpt_stb = 1'b0;
    n_cmp++; if (ovf !== 1'b1 || drop_cnt !== 8'd1) begin n_fail++; $display("FAIL sat_clr_drop got=%b/%0d exp=1/1", ovf, drop_cnt); end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    collect(32, 300);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rcv_q.size() == 0) begin n_fail++; $display("FAIL sat_char got=none exp=%h", e); end
      else begin g = rcv_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL sat_char got=%h exp=%h", g, e); end end
    end
  endtask

  task automatic test_zero_change();
    int seen;
    send_report(16'h5A5A, 16'h0000);
    send_report(16'hA5A5, 16'h0000);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (busy !== 1'b0 || uart_valid !== 1'b0) seen++;
      @(negedge clk);
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL zero_activity got=%0d exp=0", seen); end
    n_cmp++; if (drop_cnt !== 8'd0 || ovf !== 1'b0) begin n_fail++; $display("FAIL zero_drop got=%b/%0d exp=0/0", ovf, drop_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] st;
    logic [15:0] ch;
    logic [7:0]  e;
    logic [7:0]  g;
    for (int r = 0; r < 6; r++) begin
      st = 16'($urandom_range(0, 16'hFFFF));
      ch = 16'($urandom_range(1, 16'hFFFF));
      exp_push(st, ch);
      send_report(st, ch);
      collect($countones(ch), 200);
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (rcv_q.size() == 0) begin n_fail++; $display("FAIL b2b_char got=none exp=%h", e); end
        else begin g = rcv_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL b2b_char got=%h exp=%h", g, e); end end
      end
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    logic [7:0] e;
    logic [7:0] g;
    send_report(16'h0155, 16'h03FF);
    rpt_stb = 1'b1;
    @(negedge clk);
    rpt_stb = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++; if (busy !== 1'b1 || ovf !== 1'b1) begin n_fail++; $display("FAIL mid_pre got=%b/%b exp=1/1", busy, ovf); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (uart_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got=%b exp=0", uart_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
    n_cmp++; if (ovf !== 1'b0 || drop_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_flags got=%b/%0d exp=0/0", ovf, drop_cnt); end
    rst = 1'b0;
    exp_q.delete();
    rcv_q.delete();
    @(negedge clk);
    exp_push(16'h0200, 16'h0300);
    send_report(16'h0200, 16'h0300);
    collect(2, 40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_cmp++;
      if (rcv_q.size() == 0) begin n_fail++; $display("FAIL mid_char got=none exp=%h", e); end
      else begin g = rcv_q.pop_front(); if (g !== e) begin n_fail++; $display("FAIL mid_char got=%h exp=%h", g, e); end end
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (uart_valid !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL mid_leftover got=%0d exp=0", seen); end
  endtask

  initial begin
    n_cmp      = 0;
    n_fail     = 0;
    rst        = 1'b1;
    rpt_state  = '0;
    rpt_change = '0;
    rpt_stb    = 1'b0;
    uart_ack   = 1'b0;
    ovf_clr    = 1'b0;
    ack_data   = '0;
    test_reset();
    test_single();
    test_multi();
    test_fill();
    test_saturate();
    test_zero_change();
    test_back_to_back();
    test_reset_mid();
    n_cmp++;
    if (rcv_q.size() != 0) begin n_fail++; $display("FAIL unexpected_chars got=%0d exp=0", rcv_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
